// File: rtl/counter_pkg.sv
// counter_pkg: shared direction and overflow-mode constants for the up/down counter
package counter_pkg;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
endpackage

// File: rtl/updown_counter_n_if.sv
// updown_counter_n_if: control inputs and count/status outputs of the up/down counter
interface updown_counter_n_if #(parameter int WIDTH = 4);
  logic en;
  logic inst;
  logic [WIDTH-1:0] step;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] num;
  logic ovf;
  logic unf;
  logic zero;
  logic full;
  modport master (output en, inst, step, load, load_val, input num, ovf, unf, zero, full);
  modport slave (input en, inst, step, load, load_val, output num, ovf, unf, zero, full);
endinterface

// File: rtl/addsub_n.sv
// addsub_n: combinational WIDTH-bit adder/subtractor, carry_borrow=1 on add carry or subtract borrow
module addsub_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry_borrow
);
  logic [WIDTH:0] s;
  assign s = {1'b0, a} + {1'b0, sub ? ~b : b} + {{WIDTH{1'b0}}, sub};
  assign result = s[WIDTH-1:0];
  assign carry_borrow = s[WIDTH] ^ sub;
endmodule

// File: rtl/updown_counter_n.sv
// updown_counter_n: WIDTH-bit up/down counter with step, load, enable, wrap/saturate and ovf/unf pulses
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SAT = MODE_WRAP,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic rst,
  updown_counter_n_if.slave bus
);
  logic [WIDTH-1:0] num_q, num_d, res;
  logic cb, clamp, ovf_q, unf_q, ovf_d, unf_d;
  addsub_n #(.WIDTH(WIDTH)) u_addsub (
    .a(num_q),
    .b(bus.step),
    .sub(bus.inst),
    .result(res),
    .carry_borrow(cb)
  );
  // next count: load beats enable; saturate mode clamps to the rail on carry/borrow
  always_comb begin
    clamp = (SAT == MODE_SAT) && cb;
    num_d = bus.load ? bus.load_val
          : !bus.en ? num_q
          : clamp ? (bus.inst == DIR_DN ? {WIDTH{1'b0}} : {WIDTH{1'b1}})
          : res;
    ovf_d = !bus.load && bus.en && bus.inst == DIR_UP && cb;
    unf_d = !bus.load && bus.en && bus.inst == DIR_DN && cb;
  end
  // count and pulse registers, cleared asynchronously by active-low rst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_q <= RESET_VAL;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      num_q <= num_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign bus.num = num_q;
  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;
  assign bus.zero = num_q == {WIDTH{1'b0}};
  assign bus.full = &num_q;
endmodule
